// File: rtl/reg_fifo_pkg.sv
// Shared defaults and width derivations for the register FIFO.
package reg_fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module reg_fifo_mem
  import reg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/reg_fifo.sv
// First-word-fall-through register FIFO with occupancy-counter flags.
// Optional occupancy port enabled by defining REG_FIFO_COUNT_EN.
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PW = ptr_width(DEPTH),
  localparam int unsigned CW = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready
`ifdef REG_FIFO_COUNT_EN
  ,
  output logic [CW-1:0]    count
`endif
);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] rdata;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign I_ready = ~full;
  assign O_valid = ~empty;
  assign push    = I_valid & I_ready;
  assign pop     = O_valid & O_ready;
  // Stale storage is masked so the output reads zero whenever nothing is queued.
  assign O       = empty ? '0 : rdata;

`ifdef REG_FIFO_COUNT_EN
  assign count = cnt_q;
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  reg_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wptr_q),
    .wdata (I),
    .raddr (rptr_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_reg_fifo.sv
// Self-checking bench for reg_fifo against a queue-based reference model.
module tb_reg_fifo;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic          CLK;
  logic          ASYNCRESETN;
  logic [W-1:0]  I;
  logic          I_valid;
  logic          I_ready;
  logic [W-1:0]  O;
  logic          O_valid;
  logic          O_ready;
`ifdef REG_FIFO_COUNT_EN
  logic [2:0]    count;
`endif

  int unsigned passed;
  int unsigned total;
  logic [W-1:0] q [$];

  reg_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I           (I),
    .I_valid     (I_valid),
    .I_ready     (I_ready),
    .O           (O),
    .O_valid     (O_valid),
    .O_ready     (O_ready)
`ifdef REG_FIFO_COUNT_EN
    ,
    .count       (count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply one cycle of stimulus, advance the model by the FIFO rules, return at edge+1.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    logic do_push, do_pop;
    I       = d;
    I_valid = v;
    O_ready = r;
    do_push = v && (q.size() < D);
    do_pop  = r && (q.size() > 0);
    @(posedge CLK);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0; I = '0; I_valid = 1'b0; O_ready = 1'b0;
    q.delete();
    #12;
    total++; if (I_ready !== 1'b1) $display("FAIL rst_iready got %b want 1", I_ready); else passed++;
    total++; if (O_valid !== 1'b0) $display("FAIL rst_ovalid got %b want 0", O_valid); else passed++;
    total++; if (O !== 16'h0000) $display("FAIL rst_o got %h want 0000", O); else passed++;
`ifdef REG_FIFO_COUNT_EN
    total++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else passed++;
`endif
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    cyc(1'b0, '0, 1'b0);
    total++; if (I_ready !== 1'b1 || O_valid !== 1'b0) $display("FAIL idle_flags got %b%b want 10", I_ready, O_valid); else passed++;
    total++; if (O !== 16'h0000) $display("FAIL idle_o got %h want 0000", O); else passed++;
  endtask

  task automatic test_single_push();
    cyc(1'b1, 16'h00A1, 1'b0);
    total++; if (O_valid !== 1'b1) $display("FAIL push1_ovalid got %b want 1", O_valid); else passed++;
    total++; if (O !== 16'h00A1) $display("FAIL push1_o got %h want 00a1", O); else passed++;
`ifdef REG_FIFO_COUNT_EN
    total++; if (count !== 3'd1) $display("FAIL push1_count got %0d want 1", count); else passed++;
`endif
    cyc(1'b0, '0, 1'b1);
    total++; if (O_valid !== 1'b0) $display("FAIL push1_drain got %b want 0", O_valid); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] exp;
    for (int unsigned k = 1; k <= 4; k++) cyc(1'b1, W'(k), 1'b0);
    total++; if (I_ready !== 1'b0) $display("FAIL full_iready got %b want 0", I_ready); else passed++;
`ifdef REG_FIFO_COUNT_EN
    total++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else passed++;
`endif
    cyc(1'b1, 16'h0005, 1'b0);
    total++; if (I_ready !== 1'b0 || O !== 16'h0001) $display("FAIL full_reject got rdy=%b o=%h want rdy=0 o=0001", I_ready, O); else passed++;
    for (int unsigned k = 1; k <= 4; k++) begin
      exp = W'(k);
      total++; if (O !== exp || O_valid !== 1'b1) $display("FAIL drain_%0d got %h/%b want %h/1", k, O, O_valid, exp); else passed++;
      cyc(1'b0, '0, 1'b1);
    end
    total++; if (O_valid !== 1'b0 || O !== 16'h0000) $display("FAIL drain_empty got %b/%h want 0/0000", O_valid, O); else passed++;
    cyc(1'b0, '0, 1'b1);
    total++; if (I_ready !== 1'b1 || O_valid !== 1'b0) $display("FAIL underflow got %b%b want 10", I_ready, O_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    cyc(1'b1, 16'h0010, 1'b0);
    cyc(1'b1, 16'h0011, 1'b0);
    for (int unsigned k = 0; k < 10; k++) begin
      exp = 16'h0010 + W'(k);
      total++; if (O !== exp) $display("FAIL b2b_o_%0d got %h want %h", k, O, exp); else passed++;
      cyc(1'b1, 16'h0012 + W'(k), 1'b1);
`ifdef REG_FIFO_COUNT_EN
      total++; if (count !== 3'd2) $display("FAIL b2b_count_%0d got %0d want 2", k, count); else passed++;
`else
      total++; if (O_valid !== 1'b1 || I_ready !== 1'b1) $display("FAIL b2b_flags_%0d got %b%b want 11", k, O_valid, I_ready); else passed++;
`endif
    end
    total++; if (O !== 16'h001A) $display("FAIL b2b_head got %h want 001a", O); else passed++;
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 16'h0101, 1'b0);
    cyc(1'b1, 16'h0102, 1'b0);
    cyc(1'b1, 16'h0103, 1'b0);
    I_valid = 1'b0;
    #2 ASYNCRESETN = 1'b0;
    #1;
    total++; if (O_valid !== 1'b0 || O !== 16'h0000 || I_ready !== 1'b1) $display("FAIL arst got v=%b o=%h r=%b want v=0 o=0000 r=1", O_valid, O, I_ready); else passed++;
`ifdef REG_FIFO_COUNT_EN
    total++; if (count !== 3'd0) $display("FAIL arst_count got %0d want 0", count); else passed++;
`endif
    #1 ASYNCRESETN = 1'b1;
    q.delete();
    @(posedge CLK); #1;
    cyc(1'b1, 16'hBEEF, 1'b0);
    total++; if (O !== 16'hBEEF || O_valid !== 1'b1) $display("FAIL arst_beef got %h/%b want beef/1", O, O_valid); else passed++;
    cyc(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] exp_o;
    int unsigned  errs;
    errs = 0;
    for (int unsigned k = 0; k < 1000; k++) begin
      cyc(($urandom_range(99) < 60), W'($urandom), ($urandom_range(99) < 50));
      exp_o = (q.size() > 0) ? q[0] : '0;
      total++;
      if (O !== exp_o || O_valid !== (q.size() > 0) || I_ready !== (q.size() < D)) begin
        errs++;
        if (errs <= 10) $display("FAIL rand_%0d got o=%h v=%b r=%b want o=%h v=%b r=%b", k, O, O_valid, I_ready, exp_o, (q.size() > 0), (q.size() < D));
      end else passed++;
`ifdef REG_FIFO_COUNT_EN
      total++; if (count !== 3'(q.size())) $display("FAIL rand_count_%0d got %0d want %0d", k, count, q.size()); else passed++;
`endif
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
